// File: rtl/aemb2_pipe_sched_pkg.sv
// Shared definitions for the AEMB2 pipeline sequencer: scheduler state
// encoding, default timing constants and the bus-wait decode.
package aemb2_pkg;

  typedef enum logic [1:0] {
    SCH_INIT = 2'd0,
    SCH_RUN  = 2'd1,
    SCH_TMO  = 2'd2
  } sch_state_t;

  localparam int AEMB2_INIT_CYC = 4;
  localparam int AEMB2_TMO_CYC  = 255;

  // Data or FSL request still waiting on its acknowledge.
  function automatic logic dwait_f(
    input logic dwb_stb,
    input logic dwb_ack,
    input logic fsl_stb,
    input logic fsl_ack
  );
    return (dwb_stb & ~dwb_ack) | (fsl_stb & ~fsl_ack);
  endfunction

endpackage

// File: rtl/aemb2_pipe_sched_if.sv
// Handshake and stage-enable bundle between the AEMB2 core stages and the
// pipeline sequencer.
interface aemb2_pipe_sched_if;
  import aemb2_pkg::*;

  // Handshake: each stb is a request level held by its owner until the cycle
  // its ack is high; that cycle completes the transfer. ich_ack alone marks a
  // valid fetch word for the current cycle.
  logic       ich_ack;
  logic       dwb_stb;
  logic       dwb_ack;
  logic       fsl_stb;
  logic       fsl_ack;

  logic       dena;
  logic       iena;
  logic       gpha;
  logic       bus_tmo;
  logic       init_done;
  sch_state_t dbg_state;

  modport master (
    output ich_ack, dwb_stb, dwb_ack, fsl_stb, fsl_ack,
    input  dena, iena, gpha, bus_tmo, init_done, dbg_state
  );

  modport slave (
    input  ich_ack, dwb_stb, dwb_ack, fsl_stb, fsl_ack,
    output dena, iena, gpha, bus_tmo, init_done, dbg_state
  );

endinterface

// File: rtl/aemb2_pipe_sched_tmo_cnt.sv
// Saturating 8-bit bus watchdog: counts consecutive stalled cycles and flags
// the cycle whose stall would reach the limit.
module aemb2_tmo_cnt (
  input  logic       gclk,
  input  logic       grst,
  input  logic       clear,
  input  logic       increment,
  input  logic [7:0] limit,
  output logic       expire
);

  logic [7:0] tcnt;

  always_ff @(posedge gclk) begin
    if (grst || clear) begin
      tcnt <= 8'd0;
    end else if (increment && (tcnt != 8'hff)) begin
      tcnt <= tcnt + 8'd1;
    end
  end

  // A zero limit disables expiry; the counter keeps running regardless.
  assign expire = increment && (limit != 8'd0) && (tcnt == (limit - 8'd1));

endmodule

// File: rtl/aemb2_pipe_sched.sv
// AEMB2 pipeline sequencer: stage enables, thread phase, post-reset flush
// window and the bus-timeout watchdog that forces a stuck pipeline forward.
module aemb2_pipe_sched
  import aemb2_pkg::*;
#(
  parameter int AEMB_HTX = 1,
  parameter int INIT_CYC = AEMB2_INIT_CYC,
  parameter int TMO_CYC  = AEMB2_TMO_CYC
) (
  input  logic             gclk,
  input  logic             grst,
  aemb2_pipe_sched_if.slave sif
);

  localparam logic [3:0] INIT_LAST = 4'(INIT_CYC - 1);
  localparam logic [7:0] TMO_LIM   = 8'(TMO_CYC);

  sch_state_t state;
  sch_state_t state_nxt;
  logic [3:0] icnt;
  logic [3:0] icnt_nxt;
  logic       gpha_q;

  logic       dwait;
  logic       dena_c;
  logic       iena_c;
  logic       bus_tmo_c;
  logic       init_done_c;
  logic       tmo_clr;
  logic       tmo_inc;
  logic       tmo_expire;

  assign dwait = dwait_f(sif.dwb_stb, sif.dwb_ack, sif.fsl_stb, sif.fsl_ack);

  aemb2_tmo_cnt u_tmo_cnt (
    .gclk      (gclk),
    .grst      (grst),
    .clear     (tmo_clr),
    .increment (tmo_inc),
    .limit     (TMO_LIM),
    .expire    (tmo_expire)
  );

  always_ff @(posedge gclk) begin
    if (grst) begin
      state <= SCH_INIT;
      icnt  <= 4'd0;
    end else begin
      state <= state_nxt;
      icnt  <= icnt_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    icnt_nxt    = icnt;
    dena_c      = 1'b0;
    iena_c      = 1'b0;
    bus_tmo_c   = 1'b0;
    init_done_c = 1'b0;
    tmo_clr     = 1'b1;
    tmo_inc     = 1'b0;
    case (state)
      SCH_INIT: begin
        icnt_nxt = icnt + 4'd1;
        if (icnt == INIT_LAST) begin
          state_nxt = SCH_RUN;
        end
      end
      SCH_RUN: begin
        iena_c      = ~dwait;
        dena_c      = ~dwait & sif.ich_ack;
        init_done_c = 1'b1;
        tmo_clr     = ~dwait;
        tmo_inc     = dwait;
        if (tmo_expire) begin
          state_nxt = SCH_TMO;
        end
      end
      SCH_TMO: begin
        // Abandon the stuck transfer: push every stage forward once.
        dena_c      = 1'b1;
        iena_c      = 1'b1;
        bus_tmo_c   = 1'b1;
        init_done_c = 1'b1;
        state_nxt   = SCH_RUN;
      end
      default: begin
        state_nxt = SCH_INIT;
      end
    endcase
  end

  // Phase only moves with the pipeline so each thread's context stays
  // attached to its stalled instruction.
  always_ff @(posedge gclk) begin
    if (grst) begin
      gpha_q <= 1'b0;
    end else if ((AEMB_HTX != 0) && dena_c) begin
      gpha_q <= ~gpha_q;
    end
  end

  assign sif.dena      = dena_c & ~grst;
  assign sif.iena      = iena_c & ~grst;
  assign sif.bus_tmo   = bus_tmo_c & ~grst;
  assign sif.init_done = init_done_c & ~grst;
  assign sif.gpha      = gpha_q & ~grst;
  assign sif.dbg_state = state;

endmodule

// File: tb/tb_aemb2_pipe_sched.sv
// Bench for aemb2_pipe_sched: two instances (threaded with an 8-cycle
// watchdog, unthreaded with the watchdog off) against a cycle-level model.
module tb_aemb2_pipe_sched;
  import aemb2_pkg::*;

  localparam int HTX_A = 1, INIT_A = 4, TMO_A = 8;
  localparam int HTX_B = 0, INIT_B = 3, TMO_B = 0;

  // clock / reset
  logic gclk = 1'b0;
  logic tb_grst = 1'b1;
  always #5 gclk = ~gclk;

  logic tb_ich = 1'b1, tb_dstb = 1'b0, tb_dack = 1'b0, tb_fstb = 1'b0, tb_fack = 1'b0;

  aemb2_pipe_sched_if sif_a ();
  aemb2_pipe_sched_if sif_b ();

  assign sif_a.ich_ack = tb_ich;
  assign sif_a.dwb_stb = tb_dstb;
  assign sif_a.dwb_ack = tb_dack;
  assign sif_a.fsl_stb = tb_fstb;
  assign sif_a.fsl_ack = tb_fack;
  assign sif_b.ich_ack = tb_ich;
  assign sif_b.dwb_stb = tb_dstb;
  assign sif_b.dwb_ack = tb_dack;
  assign sif_b.fsl_stb = tb_fstb;
  assign sif_b.fsl_ack = tb_fack;

  aemb2_pipe_sched #(.AEMB_HTX(HTX_A), .INIT_CYC(INIT_A), .TMO_CYC(TMO_A)) dut_a (
    .gclk (gclk),
    .grst (tb_grst),
    .sif  (sif_a.slave)
  );

  aemb2_pipe_sched #(.AEMB_HTX(HTX_B), .INIT_CYC(INIT_B), .TMO_CYC(TMO_B)) dut_b (
    .gclk (gclk),
    .grst (tb_grst),
    .sif  (sif_b.slave)
  );

  int checks = 0;
  int failures = 0;

  // Behavioural model: cycles since reset, consecutive stalled cycles,
  // pending forced advance, and thread phase, per instance.
  int m_since[2];
  int m_stall[2];
  bit m_tmo[2];
  bit m_gpha[2];
  logic [4:0] exp_q[$];
  bit e_dena[2];

  initial begin
    for (int i = 0; i < 2; i++) begin
      m_since[i] = 0; m_stall[i] = 0; m_tmo[i] = 0; m_gpha[i] = 0; e_dena[i] = 0;
    end
  end

  function automatic bit in_dwait();
    return (tb_dstb && !tb_dack) || (tb_fstb && !tb_fack);
  endfunction

  // {dena, iena, gpha, bus_tmo, init_done}
  function automatic logic [4:0] model_out(input int i);
    int init_c;
    bit dw;
    init_c = (i == 0) ? INIT_A : INIT_B;
    dw = in_dwait();
    if (tb_grst) return 5'b00000;
    if (m_since[i] < init_c) return {1'b0, 1'b0, m_gpha[i], 1'b0, 1'b0};
    if (m_tmo[i]) return {1'b1, 1'b1, m_gpha[i], 1'b1, 1'b1};
    return {(!dw && tb_ich), !dw, m_gpha[i], 1'b0, 1'b1};
  endfunction

  always @(posedge gclk) begin
    for (int i = 0; i < 2; i++) begin
      int init_c, tmo_c, htx_c;
      init_c = (i == 0) ? INIT_A : INIT_B;
      tmo_c  = (i == 0) ? TMO_A : TMO_B;
      htx_c  = (i == 0) ? HTX_A : HTX_B;
      if (tb_grst) begin
        m_since[i] = 0; m_stall[i] = 0; m_tmo[i] = 0; m_gpha[i] = 0;
      end else begin
        if (htx_c != 0 && e_dena[i]) m_gpha[i] = !m_gpha[i];
        if (m_since[i] < init_c) begin
          m_since[i] = m_since[i] + 1;
        end else if (m_tmo[i]) begin
          m_tmo[i] = 0; m_stall[i] = 0;
        end else if (in_dwait()) begin
          m_stall[i] = m_stall[i] + 1;
          if (tmo_c != 0 && m_stall[i] == tmo_c) m_tmo[i] = 1;
        end else begin
          m_stall[i] = 0;
        end
      end
    end
  end

  // scoreboard: every negedge, model expectation vs both DUTs
  always @(negedge gclk) begin
    logic [4:0] got;
    for (int i = 0; i < 2; i++) exp_q.push_back(model_out(i));
    for (int i = 0; i < 2; i++) begin
      logic [4:0] exp_v;
      exp_v = exp_q.pop_front();
      got = (i == 0) ? {sif_a.dena, sif_a.iena, sif_a.gpha, sif_a.bus_tmo, sif_a.init_done}
                     : {sif_b.dena, sif_b.iena, sif_b.gpha, sif_b.bus_tmo, sif_b.init_done};
      checks++;
      if (got !== exp_v) begin
        failures++;
        $display("FAIL model_cmp inst=%0d t=%0t {dena,iena,gpha,bus_tmo,init_done} got=%b exp=%b",
                 i, $time, got, exp_v);
      end
      e_dena[i] = exp_v[4];
    end
  end

  task automatic chk(input string name, input logic got, input logic exp_v);
    checks++;
    if (got !== exp_v) begin
      failures++;
      $display("FAIL %s t=%0t got=%b exp=%b", name, $time, got, exp_v);
    end
  endtask

  // driver: apply inputs just after the edge, return at the next negedge
  task automatic step(input logic ich, input logic dstb, input logic dack,
                      input logic fstb, input logic fack);
    @(posedge gclk);
    #1;
    tb_ich = ich; tb_dstb = dstb; tb_dack = dack; tb_fstb = fstb; tb_fack = fack;
    @(negedge gclk);
  endtask

  initial begin
    // reset flush
    repeat (2) @(posedge gclk);
    #1 tb_grst = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge gclk);
      chk("flush_dena", sif_a.dena, k >= 5);
      chk("flush_iena", sif_a.iena, k >= 5);
      chk("flush_init_done", sif_a.init_done, k >= 5);
      chk("flush_gpha", sif_a.gpha, (k >= 6) && ((k % 2) == 0));
      chk("flush_b_init_done", sif_b.init_done, k >= 4);
    end

    // data stall, ack on third cycle
    step(1, 0, 0, 0, 0);
    chk("idle_gpha", sif_a.gpha, 1'b0);
    for (int n = 1; n <= 3; n++) begin
      step(1, 1, n == 3, 0, 0);
      chk("stall_dena", sif_a.dena, n == 3);
      chk("stall_iena", sif_a.iena, n == 3);
      chk("stall_gpha", sif_a.gpha, 1'b1);
      chk("stall_bus_tmo", sif_a.bus_tmo, 1'b0);
    end
    step(1, 0, 0, 0, 0);
    chk("post_stall_gpha", sif_a.gpha, 1'b0);

    // timeout, stb held with no ack
    for (int n = 1; n <= 18; n++) begin
      step(1, 1, 0, 0, 0);
      chk("tmo_dena", sif_a.dena, (n == 9) || (n == 18));
      chk("tmo_bus_tmo", sif_a.bus_tmo, (n == 9) || (n == 18));
      chk("tmo_b_dena", sif_b.dena, 1'b0);
      chk("tmo_b_bus_tmo", sif_b.bus_tmo, 1'b0);
    end

    // ack on the limit cycle: dwb then fsl
    step(1, 0, 0, 0, 0);
    for (int n = 1; n <= 8; n++) begin
      step(1, 1, n == 8, 0, 0);
      chk("acklim_dena", sif_a.dena, n == 8);
      chk("acklim_bus_tmo", sif_a.bus_tmo, 1'b0);
    end
    step(1, 0, 0, 0, 0);
    chk("acklim_after_tmo", sif_a.bus_tmo, 1'b0);
    for (int n = 1; n <= 8; n++) begin
      step(1, 0, 0, 1, n == 8);
      chk("fsl_acklim_dena", sif_a.dena, n == 8);
      chk("fsl_acklim_bus_tmo", sif_a.bus_tmo, 1'b0);
    end
    step(1, 0, 0, 0, 0);
    chk("fsl_acklim_after_tmo", sif_a.bus_tmo, 1'b0);

    // fetch miss
    for (int n = 1; n <= 2; n++) begin
      step(0, 0, 0, 0, 0);
      chk("miss_iena", sif_a.iena, 1'b1);
      chk("miss_dena", sif_a.dena, 1'b0);
    end
    step(1, 0, 0, 0, 0);
    chk("miss_resume_dena", sif_a.dena, 1'b1);

    // reset mid timeout count
    for (int n = 1; n <= 5; n++) step(1, 1, 0, 0, 0);
    @(posedge gclk);
    #1 tb_grst = 1'b1;
    @(negedge gclk);
    chk("rst_dena", sif_a.dena, 1'b0);
    chk("rst_iena", sif_a.iena, 1'b0);
    chk("rst_bus_tmo", sif_a.bus_tmo, 1'b0);
    chk("rst_init_done", sif_a.init_done, 1'b0);
    chk("rst_gpha", sif_a.gpha, 1'b0);
    @(posedge gclk);
    #1 tb_grst = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      @(negedge gclk);
      chk("rst_state_init", sif_a.dbg_state == SCH_INIT, 1'b1);
      chk("rst_init_bus_tmo", sif_a.bus_tmo, 1'b0);
    end
    for (int n = 1; n <= 9; n++) begin
      step(1, 1, 0, 0, 0);
      chk("rst_tcnt_cleared", sif_a.bus_tmo, n == 9);
    end

    // unthreaded instance keeps phase 0 while advancing
    for (int n = 1; n <= 20; n++) begin
      step(1, 0, 0, 0, 0);
      chk("htx0_gpha", sif_b.gpha, 1'b0);
      chk("htx0_dena", sif_b.dena, 1'b1);
    end

    // randomized traffic; includes one long hold past counter saturation
    for (int seg = 0; seg < 300; seg++) begin
      int mode;
      int len;
      mode = $urandom_range(0, 19);
      if (mode == 0) begin
        @(posedge gclk);
        #1 tb_grst = 1'b1;
        repeat ($urandom_range(1, 2)) @(posedge gclk);
        #1 tb_grst = 1'b0;
      end else if (mode <= 3) begin
        len = (seg == 150) ? 270 : $urandom_range(5, 20);
        for (int n = 0; n < len; n++) step($urandom_range(0, 1), 1, 0, 0, 0);
      end else begin
        len = $urandom_range(3, 12);
        for (int n = 0; n < len; n++)
          step($urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0, $urandom_range(0, 1),
               $urandom_range(0, 3) == 0, $urandom_range(0, 1));
      end
      if (seg == 150 && mode != 1 && mode != 2 && mode != 3)
        for (int n = 0; n < 270; n++) step(1, 0, 0, 1, 0);
    end
    step(1, 0, 0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/aemb2_pipe_sched.md
Name: aemb2_pipe_sched

Overview:
Pipeline sequencer and hardware-thread scheduler for the AEMB2 core. It generates the global stage enables (dena, iena) and the thread phase (gpha) that the decode/control, register and execute stages consume. It stalls the pipeline while instruction fetch, data bus or FSL transactions are outstanding. It holds a post-reset flush window and a bus-timeout watchdog that forces the pipeline forward and flags an error.

Parameters:
AEMB_HTX, 1, hardware threading enable; 1 = gpha alternates per advance, 0 = gpha tied 0
INIT_CYC, 4, cycles after reset with pipeline held (range 1..15)
TMO_CYC, 255, consecutive data-stall cycles before timeout (range 1..255); 0 disables the watchdog

Ports:
gclk  in  1  core clock; all state updates on rising edge
grst  in  1  reset; one clock; synchronous, active-high
ich_ack  in  1  instruction fetch word valid this cycle
dwb_stb  in  1  data bus request outstanding from the memory stage
dwb_ack  in  1  data bus acknowledge
fsl_stb  in  1  FSL get/put outstanding
fsl_ack  in  1  FSL acknowledge
dena  out  1  data/pipeline stage enable
iena  out  1  instruction fetch enable
gpha  out  1  current thread phase (0 = thread 0, 1 = thread 1)
bus_tmo  out  1  one-cycle pulse: data/FSL transaction abandoned by watchdog
init_done  out  1  high once the INIT window has expired

Behaviour:
- States: INIT, RUN, TMO. Registers: state, icnt[3:0], tcnt[7:0], gpha.
- Reset (grst=1 at an edge): state=INIT, icnt=0, tcnt=0, gpha=0. While grst is high, all outputs are 0 combinationally.
- dwait = (dwb_stb & !dwb_ack) | (fsl_stb & !fsl_ack).
- INIT:
  - dena=0, iena=0, init_done=0.
  - icnt increments each cycle; at icnt==INIT_CYC-1 the next state is RUN.
  - Exactly INIT_CYC cycles are spent in INIT after grst deasserts.
- RUN:
  - iena = !dwait.
  - dena = !dwait & ich_ack.
  - init_done=1.
  - tcnt increments while dwait and clears whenever !dwait.
  - If TMO_CYC!=0, dwait, and tcnt==TMO_CYC-1, the next state is TMO.
- TMO (exactly one cycle):
  - dena=1, iena=1, bus_tmo=1, tcnt cleared; next state RUN.
  - The forced advance happens regardless of dwait and ich_ack.
- bus_tmo is 0 in all states other than TMO.
- gpha:
  - When AEMB_HTX=1, gpha toggles at each edge where dena=1.
  - It holds during stalls, so both threads keep their imm-prefix and forwarding context aligned with the stalled instruction.
  - When AEMB_HTX=0, gpha is constant 0.
- Outputs are combinational from registered state plus handshake inputs. There is no combinational path from dena or iena back into state other than through gpha and the counters.
- Simultaneous dwb_ack and timeout edge: an ack in the cycle where tcnt==TMO_CYC-1 makes dwait=0. The state stays RUN, there is no timeout, and tcnt clears.
- Reset mid-stall or mid-TMO: the state goes to INIT immediately, no bus_tmo pulse is emitted, and gpha returns to 0.
- tcnt saturates at its maximum and never wraps. With TMO_CYC=0 the counter still runs but is ignored.
- ich_ack low with dwait low: iena=1, dena=0, so fetch retries and the pipeline holds.

Decomposition:
- Shared package aemb2_pkg:
  - state encoding SCH_INIT=2'd0, SCH_RUN=2'd1, SCH_TMO=2'd2;
  - default constants AEMB2_INIT_CYC=4, AEMB2_TMO_CYC=255.
- One sub-module is natural: aemb2_tmo_cnt, the saturating 8-bit watchdog.
  - Inputs: clear, increment, limit.
  - Output: expire.
- The FSM, enables and gpha stay in aemb2_pipe_sched.

Test Plan:
- Reset flush: grst high for 2 cycles, then low, with ich_ack=1 and no stb -> dena=iena=0 for exactly 4 cycles; init_done rises on cycle 5; dena=1 from cycle 5; gpha toggles 0,1,0,1 from cycle 6.
- Data stall: in RUN raise dwb_stb for 3 cycles, dwb_ack on the 3rd -> dena=iena=0 for 2 cycles and 1 on the ack cycle; gpha frozen during the stall; bus_tmo never asserts.
- Timeout: TMO_CYC=8, dwb_stb held high with no ack -> dena=0 for 8 cycles, then one cycle with dena=1 and bus_tmo=1; returns to RUN; stall resumes while stb stays high, with the next timeout 9 cycles later.
- Ack on limit: TMO_CYC=8, dwb_ack arrives on the 8th stall cycle -> no TMO, bus_tmo=0, dena=1 that cycle.
- Fetch miss: ich_ack low for 2 cycles, no dwait -> iena=1, dena=0; gpha holds; advance resumes when ich_ack=1.
- Reset mid-timeout-count (tcnt=5) and AEMB_HTX=0 run -> state INIT, tcnt=0, no bus_tmo; with HTX=0, gpha stays 0 across 20 advancing cycles.
